out_drain_ctrl: RTL
===================

OUT_DRAIN_CTRL -- requirements
Module: out_drain_ctrl

Interface
REQ-001 The module SHALL have parameter DW, default 16, giving the result word width.
REQ-002 The module SHALL have parameter NUM_OUT, default 10, giving the number of output registers per frame (b11..b44 upper-triangular result).
REQ-003 The module SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port frame_done  input  1  one-cycle pulse: all NUM_OUT output registers are loaded.
REQ-006 The module SHALL have port ovr_clr  input  1  clears the overrun flag.
REQ-007 The module SHALL have port rd_data  input  DW  data of the output register selected by rd_sel.
REQ-008 The module SHALL have port m_ready  input  1  downstream sink accepts m_data.
REQ-009 The module SHALL have port rd_sel  output  4  output-register select, 1..NUM_OUT; 0 = none.
REQ-010 The module SHALL have port m_data  output  DW  registered result word.
REQ-011 The module SHALL have port m_valid  output  1  m_data is valid.
REQ-012 The module SHALL have port m_last  output  1  current word is the last word of the frame.
REQ-013 The module SHALL have port busy  output  1  a drain is in progress; upstream holds its out_sclr while high.
REQ-014 The module SHALL have port drain_done  output  1  one-cycle pulse after the final word is accepted.
REQ-015 The module SHALL have port overrun  output  1  sticky: frame_done arrived while busy.

Function
REQ-016 The FSM SHALL have states IDLE, SEL and SEND, plus a 4-bit word index idx.
REQ-017 In IDLE, a frame_done pulse SHALL set idx=1 and move the FSM to SEL; otherwise the FSM SHALL remain in IDLE.
REQ-018 In SEL, rd_sel SHALL equal idx, and on the next edge rd_data SHALL be captured into m_data, m_valid set to 1, and the FSM moved to SEND.
REQ-019 In SEND, the FSM SHALL hold while m_ready=0, keeping m_data, m_last and rd_sel stable.
REQ-020 In SEND, on m_valid and m_ready with idx<NUM_OUT, the module SHALL clear m_valid, increment idx and move to SEL.
REQ-021 In SEND, on m_valid and m_ready with idx=NUM_OUT, the module SHALL clear m_valid, set rd_sel=0, pulse drain_done on the next cycle and return to IDLE.
REQ-022 m_last SHALL equal 1 exactly when m_valid=1 and idx=NUM_OUT.
REQ-023 Latency SHALL be: frame_done at edge t gives rd_sel=1 in cycle t+1 and the first m_valid in cycle t+2, with 2 cycles per word minimum (2*NUM_OUT cycles per frame with m_ready held at 1).
REQ-024 busy SHALL equal 1 in SEL and SEND and 0 in IDLE; rd_sel SHALL be 0 in IDLE.
REQ-025 A frame_done pulse while busy SHALL set overrun to 1, be otherwise ignored, and leave the drain unaffected.
REQ-026 frame_done in the same cycle as the final handshake (REQ-021) SHALL be accepted as a new frame: the FSM goes to SEL with idx=1, overrun is not set, and drain_done still pulses.
REQ-027 ovr_clr=1 SHALL clear overrun on the next edge; if frame_done-while-busy and ovr_clr coincide, setting SHALL win.
REQ-028 idx SHALL never exceed NUM_OUT and SHALL never wrap within a frame.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, idx=0, rd_sel=0, m_data=0, m_valid=0, m_last=0, busy=0, drain_done=0 and overrun=0.
REQ-030 Reset asserted mid-drain SHALL abandon the frame without a drain_done pulse, and reset SHALL take priority over all inputs.

Verification
REQ-031 The bench SHALL cover this scenario: reset, rd_data=16*rd_sel, frame_done pulse, m_ready=1 held -> rd_sel 1..10, m_data 16,32,...,160, first m_valid 2 cycles after frame_done, m_last with 160 only, drain_done one cycle after, frame complete in 20 cycles.
REQ-032 The bench SHALL cover this scenario: m_ready=0 for 3 cycles while word 4 is valid -> m_data=64, m_valid=1 and rd_sel=4 stable for those cycles, no word lost or duplicated.
REQ-033 The bench SHALL cover this scenario: frame_done during word 5 -> overrun=1, words 5..10 still delivered normally, and ovr_clr pulse returns overrun to 0.
REQ-034 The bench SHALL cover this scenario: frame_done coincident with the word-10 handshake -> drain_done pulses, rd_sel=1 next cycle, overrun remains 0.
REQ-035 The bench SHALL cover this scenario: reset during word 6 -> all outputs 0 next cycle with no drain_done, and a following frame_done restarts at rd_sel=1.

Source files
------------

// File: rtl/out_drain_ctrl_if.sv
// out_drain_ctrl_if: result word stream from the drain controller to its sink
interface out_drain_ctrl_if #(parameter int DW = 16);
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/out_drain_ctrl.sv
// out_drain_ctrl: drains NUM_OUT result registers one word at a time onto a valid/ready stream
module out_drain_ctrl #(
  parameter int DW      = 16,
  parameter int NUM_OUT = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             frame_done,
  input  logic             ovr_clr,
  input  logic [DW-1:0]    rd_data,
  output logic [3:0]       rd_sel,
  output logic             busy,
  output logic             drain_done,
  output logic             overrun,
  out_drain_ctrl_if.master m
);
  localparam logic [3:0] N = 4'(NUM_OUT);
  typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d, rd_sel_q, rd_sel_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic          busy_q, busy_d, drain_done_q, drain_done_d, overrun_q, overrun_d;
  logic          hs, fin;
  always_comb begin
    hs           = state_q == SEND && m_valid_q && m.m_ready;
    fin          = hs && idx_q == N;
    state_d      = state_q;
    idx_d        = idx_q;
    rd_sel_d     = rd_sel_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    drain_done_d = fin;
    overrun_d    = (frame_done && state_q != IDLE && !fin) || (overrun_q && !ovr_clr);
    case (state_q)
      IDLE: if (frame_done) begin
        state_d  = SEL;
        idx_d    = 4'd1;
        rd_sel_d = 4'd1;
      end
      SEL: begin
        state_d   = SEND;
        m_data_d  = rd_data;
        m_valid_d = 1'b1;
        m_last_d  = idx_q == N;
      end
      SEND: if (hs) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        idx_d     = fin ? (frame_done ? 4'd1 : 4'd0) : idx_q + 4'd1;
        rd_sel_d  = idx_d;
        state_d   = fin && !frame_done ? IDLE : SEL;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_sel_q     <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_sel_q     <= rd_sel_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end
  assign rd_sel     = rd_sel_q;
  assign busy       = busy_q;
  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;
  assign m.m_data   = m_data_q;
  assign m.m_valid  = m_valid_q;
  assign m.m_last   = m_last_q;
endmodule
